// File: rtl/i2s_pkg.sv
// Shared types and default timing constants for the I2S receive controller.
package i2s_pkg;

   typedef enum logic [1:0] {IDLE, RUN, STOP} i2s_ctrl_state_t;

   localparam int unsigned I2S_DATA_BIT = 16;
   localparam int unsigned I2S_SCLK_DIV = 4;
   localparam int unsigned I2S_SLOT_BIT = 32;

   // Bit position 1 carries the MSB (one-bit I2S delay), so the index counts down from data_bit-1.
   function automatic int unsigned i2s_bit_index(input int unsigned data_bit,
                                                 input int unsigned bit_pos);
      return data_bit - bit_pos;
   endfunction

endpackage

// File: rtl/i2s_rx_ctrl_if.sv
// Run request in, codec clocks and per-bit receive qualifiers out.
interface i2s_rx_ctrl_if #(
   parameter int unsigned DATA_BIT = i2s_pkg::I2S_DATA_BIT
);

   logic                        i_enable;
   logic                        o_sclk;
   logic                        o_lrclk;
   logic                        o_sclk_tick;
   logic [$clog2(DATA_BIT)-1:0] o_count;
   logic                        o_count_valid;
   logic                        o_count_lrclk;
   logic                        o_finish;
   logic                        o_active;

   modport master (
      input  i_enable,
      output o_sclk, o_lrclk, o_sclk_tick, o_count, o_count_valid, o_count_lrclk,
             o_finish, o_active
   );

   modport slave (
      output i_enable,
      input  o_sclk, o_lrclk, o_sclk_tick, o_count, o_count_valid, o_count_lrclk,
             o_finish, o_active
   );

endinterface

// File: rtl/i2s_sclk_gen.sv
// SCLK divider: low half first, registered SCLK and sample tick, strobes for the falling edge.
module i2s_sclk_gen
   import i2s_pkg::*;
#(
   parameter int unsigned SCLK_DIV = I2S_SCLK_DIV
) (
   input  logic i_clk_12_288,
   input  logic i_reset_n,
   input  logic i_run,
   input  logic i_run_next,
   output logic o_sclk,
   output logic o_tick,
   output logic o_fall,
   output logic o_last_next
);

   localparam int unsigned   DW       = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(SCLK_DIV / 2);

   logic [DW-1:0] div_q, div_d;
   logic          sclk_q, sclk_d;
   logic          tick_q, tick_d;

   // Count only while running in both this and the next cycle, so entry and exit land on 0.
   always_comb begin
      div_d = '0;
      if (i_run && i_run_next && div_q != DIV_LAST) begin
         div_d = div_q + 1'b1;
      end
      sclk_d = i_run_next && (div_d >= DIV_HALF);
      tick_d = i_run_next && (div_d == DIV_HALF);
   end

   always_ff @(posedge i_clk_12_288 or negedge i_reset_n) begin
      if (!i_reset_n) begin
         div_q  <= '0;
         sclk_q <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         sclk_q <= sclk_d;
         tick_q <= tick_d;
      end
   end

   assign o_sclk      = sclk_q;
   assign o_tick      = tick_q;
   assign o_fall      = i_run && (div_q == DIV_LAST);
   assign o_last_next = i_run_next && (div_d == DIV_LAST);

endmodule

// File: rtl/i2s_rx_ctrl.sv
// I2S receive timing sequencer: slot/channel counters, run/stop FSM and registered bit qualifiers.
module i2s_rx_ctrl
   import i2s_pkg::*;
#(
   parameter int unsigned DATA_BIT = I2S_DATA_BIT,
   parameter int unsigned SCLK_DIV = I2S_SCLK_DIV,
   parameter int unsigned SLOT_BIT = I2S_SLOT_BIT
) (
   input  logic          i_clk_12_288,
   input  logic          i_reset_n,
   i2s_rx_ctrl_if.master bus
);

   localparam int unsigned   CW       = $clog2(DATA_BIT);
   localparam int unsigned   BW       = $clog2(SLOT_BIT);
   localparam logic [BW-1:0] BIT_LAST = BW'(SLOT_BIT - 1);
   localparam logic [BW-1:0] BIT_DATA = BW'(DATA_BIT);

   i2s_ctrl_state_t state_q, state_d;
   logic [BW-1:0]   bit_q, bit_d;
   logic            lr_q, lr_d;
   logic            active_q, active_d;
   logic            finish_q, finish_d;
   logic            valid_q, valid_d;
   logic [CW-1:0]   count_q, count_d;
   logic            sclk, tick, fall, last_next;

   i2s_sclk_gen #(
      .SCLK_DIV (SCLK_DIV)
   ) u_sclk_gen (
      .i_clk_12_288 (i_clk_12_288),
      .i_reset_n    (i_reset_n),
      .i_run        (active_q),
      .i_run_next   (active_d),
      .o_sclk       (sclk),
      .o_tick       (tick),
      .o_fall       (fall),
      .o_last_next  (last_next)
   );

   // Stopping only completes on the frame's last cycle; a drop in that cycle ends the run at once.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.i_enable) state_d = RUN;
         RUN:     if (!bus.i_enable) state_d = finish_q ? IDLE : STOP;
         STOP: begin
            if (bus.i_enable)  state_d = RUN;
            else if (finish_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      active_d = (state_d != IDLE);
   end

   always_comb begin
      bit_d = '0;
      lr_d  = 1'b0;
      if (active_q && active_d) begin
         bit_d = bit_q;
         lr_d  = lr_q;
         if (fall) begin
            if (bit_q == BIT_LAST) begin
               bit_d = '0;
               lr_d  = ~lr_q;
            end else begin
               bit_d = bit_q + 1'b1;
            end
         end
      end
   end

   // Qualifiers are derived from next-state counters so the registered outputs line up with them.
   always_comb begin
      valid_d  = active_d && (bit_d != '0) && (bit_d <= BIT_DATA);
      count_d  = valid_d ? CW'(i2s_bit_index(DATA_BIT, 32'(bit_d))) : '0;
      finish_d = active_d && lr_d && (bit_d == BIT_LAST) && last_next;
   end

   always_ff @(posedge i_clk_12_288 or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= IDLE;
         bit_q    <= '0;
         lr_q     <= 1'b0;
         active_q <= 1'b0;
         finish_q <= 1'b0;
         valid_q  <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         bit_q    <= bit_d;
         lr_q     <= lr_d;
         active_q <= active_d;
         finish_q <= finish_d;
         valid_q  <= valid_d;
         count_q  <= count_d;
      end
   end

   assign bus.o_sclk        = sclk;
   assign bus.o_lrclk       = lr_q;
   assign bus.o_sclk_tick   = tick;
   assign bus.o_count       = count_q;
   assign bus.o_count_valid = valid_q;
   assign bus.o_count_lrclk = lr_q;
   assign bus.o_finish      = finish_q;
   assign bus.o_active      = active_q;

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Bench for i2s_rx_ctrl: closed-form per-cycle timing model plus a queue of expected o_finish cycles.
module tb_i2s_rx_ctrl;
   import i2s_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #41 clk = ~clk;

   i2s_rx_ctrl_if #(.DATA_BIT(16)) bus_a ();
   i2s_rx_ctrl_if #(.DATA_BIT(24)) bus_b ();

   i2s_rx_ctrl #(
      .DATA_BIT (16),
      .SCLK_DIV (4),
      .SLOT_BIT (32)
   ) dut_a (
      .i_clk_12_288 (clk),
      .i_reset_n    (rst_n),
      .bus          (bus_a)
   );

   i2s_rx_ctrl #(
      .DATA_BIT (24),
      .SCLK_DIV (2),
      .SLOT_BIT (32)
   ) dut_b (
      .i_clk_12_288 (clk),
      .i_reset_n    (rst_n),
      .bus          (bus_b)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int ticks_b = 0;
   bit exp_on[2] = '{1'b0, 1'b0};
   int t0[2]     = '{1 << 30, 1 << 30};
   int t_end[2]  = '{-1, -1};
   int fin_q0[$];
   int fin_q1[$];

   task automatic check_eq(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // {sclk, lrclk, tick, valid, count_lrclk, active, count[4:0]}
   function automatic logic [10:0] model(input int div, input int slot, input int db,
                                         input int rel);
      int d, b, l;
      logic v;
      logic [4:0] cnt;
      d   = rel % div;
      b   = (rel / div) % slot;
      l   = (rel / (div * slot)) % 2;
      v   = (b >= 1) && (b <= db);
      cnt = v ? 5'(db - b) : 5'd0;
      return {d >= div / 2, l[0], d == div / 2, v, l[0], 1'b1, cnt};
   endfunction

   function automatic logic [10:0] pack_a();
      return {bus_a.o_sclk, bus_a.o_lrclk, bus_a.o_sclk_tick, bus_a.o_count_valid,
              bus_a.o_count_lrclk, bus_a.o_active, 1'b0, bus_a.o_count};
   endfunction

   function automatic logic [10:0] pack_b();
      return {bus_b.o_sclk, bus_b.o_lrclk, bus_b.o_sclk_tick, bus_b.o_count_valid,
              bus_b.o_count_lrclk, bus_b.o_active, bus_b.o_count};
   endfunction

   function automatic logic [10:0] expect_dut(input int i, input int div, input int db);
      if (exp_on[i] && cyc >= t0[i] && (t_end[i] < 0 || cyc <= t_end[i]))
         return model(div, 32, db, cyc - t0[i]);
      return '0;
   endfunction

   // Monitor: cycle index advances at each rising edge, outputs sampled 1 time unit later.
   always begin
      int exp_fin;
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      check_eq("outs_a", 32'(pack_a()), 32'(expect_dut(0, 4, 16)));
      check_eq("outs_b", 32'(pack_b()), 32'(expect_dut(1, 2, 24)));
      if (bus_a.o_finish) begin
         exp_fin = (fin_q0.size() != 0) ? fin_q0.pop_front() : -1;
         check_eq("fin_a", cyc, exp_fin);
      end
      if (bus_b.o_finish) begin
         exp_fin = (fin_q1.size() != 0) ? fin_q1.pop_front() : -1;
         check_eq("fin_b", cyc, exp_fin);
      end
      if (bus_b.o_sclk_tick && cyc >= t0[1] && cyc < t0[1] + 128) ticks_b++;
   end

   task automatic wait_cyc(input int c);
      do @(negedge clk); while (cyc < c);
   endtask

   task automatic start_a(input int stop_at);
      t0[0]     = cyc + 1;
      t_end[0]  = stop_at;
      exp_on[0] = 1'b1;
      bus_a.i_enable = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_a.i_enable = 1'b0;
      bus_b.i_enable = 1'b0;
      #3;
      check_eq("rst_outs_a", 32'(pack_a()), 0);
      check_eq("rst_outs_b", 32'(pack_b()), 0);
      check_eq("rst_fin_a", 32'(bus_a.o_finish), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Enable held for two frames, then dropped mid-frame: current frame completes.
      start_a(-1);
      fin_q0.push_back(t0[0] + 255);
      fin_q0.push_back(t0[0] + 511);
      wait_cyc(t0[0] + 300);
      bus_a.i_enable = 1'b0;
      t_end[0] = t0[0] + 511;
      wait_cyc(t0[0] + 520);
      check_eq("fin_left_held", fin_q0.size(), 0);

      // Single-cycle enable pulse: exactly one frame.
      start_a(cyc + 1 + 255);
      fin_q0.push_back(t0[0] + 255);
      @(negedge clk);
      bus_a.i_enable = 1'b0;
      wait_cyc(t0[0] + 300);
      check_eq("fin_left_pulse", fin_q0.size(), 0);

      // Drop at 100, reassert at 150, then drop in the very last cycle of the third frame.
      start_a(-1);
      fin_q0.push_back(t0[0] + 255);
      fin_q0.push_back(t0[0] + 511);
      fin_q0.push_back(t0[0] + 767);
      wait_cyc(t0[0] + 100);
      bus_a.i_enable = 1'b0;
      wait_cyc(t0[0] + 150);
      bus_a.i_enable = 1'b1;
      wait_cyc(t0[0] + 767);
      bus_a.i_enable = 1'b0;
      t_end[0] = t0[0] + 767;
      wait_cyc(t0[0] + 800);
      check_eq("fin_left_gap", fin_q0.size(), 0);

      // Asynchronous reset mid-frame: immediate clear, no finish for the partial frame.
      start_a(-1);
      fin_q0.push_back(t0[0] + 255);
      wait_cyc(t0[0] + 70);
      rst_n     = 1'b0;
      exp_on[0] = 1'b0;
      fin_q0.delete();
      #1;
      check_eq("rst_mid_outs", 32'(pack_a()), 0);
      check_eq("rst_mid_fin", 32'(bus_a.o_finish), 0);
      @(negedge clk);
      rst_n = 1'b1;
      start_a(-1);
      fin_q0.push_back(t0[0] + 255);
      wait_cyc(t0[0] + 10);
      bus_a.i_enable = 1'b0;
      t_end[0] = t0[0] + 255;
      wait_cyc(t0[0] + 270);
      check_eq("fin_left_rst", fin_q0.size(), 0);

      // 24-bit words, SCLK_DIV=2: 128-clk frames, 64 ticks per frame.
      ticks_b   = 0;
      t0[1]     = cyc + 1;
      t_end[1]  = -1;
      exp_on[1] = 1'b1;
      bus_b.i_enable = 1'b1;
      fin_q1.push_back(t0[1] + 127);
      fin_q1.push_back(t0[1] + 255);
      wait_cyc(t0[1] + 200);
      bus_b.i_enable = 1'b0;
      t_end[1] = t0[1] + 255;
      wait_cyc(t0[1] + 270);
      check_eq("fin_left_b", fin_q1.size(), 0);
      check_eq("ticks_b", ticks_b, 64);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
